// File: rtl/mcu_tx_scheduler_if.sv
// MCU TX scheduler bus: write side, MCU frame enable and shift-register controls.
// master = producer/MCU side, slave = scheduler.
interface mcu_tx_scheduler_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic [15:0]   wr_data;
  logic          mcu_ce;
  logic          full;
  logic [CW-1:0] count;
  logic          load;
  logic [15:0]   data_load;
  logic          transmit;
  logic          mcu_irq;

  modport master (
    output wr_en, wr_data, mcu_ce,
    input  full, count, load, data_load, transmit, mcu_irq
  );

  modport slave (
    input  wr_en, wr_data, mcu_ce,
    output full, count, load, data_load, transmit, mcu_irq
  );
endinterface

// File: rtl/mcu_tx_scheduler.sv
// MCU TX scheduler: word FIFO feeding an SPI shift register, paced by MCU frames.
// Optional macro MCU_TX_IRQ_EN drives mcu_irq while a word is armed; else it is 0.
module mcu_tx_scheduler #(
  parameter int DEPTH = 4
) (
  input logic             fpga_sck,
  input logic             reset,
  mcu_tx_scheduler_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2,
    BUSY  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_nxt;
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [15:0]   r_data;
  logic          r_load;
  logic          r_tx;
  logic          r_irq;
  logic          r_ce_m;
  logic          r_ce_s;
  logic          r_ce_d;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_rise;
  logic          w_fall;

  assign w_full = (r_count == CW'(DEPTH));
  assign w_rise = r_ce_s & ~r_ce_d;
  assign w_fall = ~r_ce_s & r_ce_d;
  assign w_pop  = (r_state == IDLE) && (r_count != '0) && !r_ce_s;
  assign w_push = bus.wr_en && (!w_full || w_pop);

  // Bring mcu_ce into the fpga_sck domain and keep a delayed copy for edges.
  always_ff @(posedge fpga_sck or posedge reset) begin
    if (reset) begin
      r_ce_m <= 1'b0;
      r_ce_s <= 1'b0;
      r_ce_d <= 1'b0;
    end else begin
      r_ce_m <= bus.mcu_ce;
      r_ce_s <= r_ce_m;
      r_ce_d <= r_ce_s;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge fpga_sck) begin
    if (w_push) r_mem[r_wptr] <= bus.wr_data;
  end

  // FIFO pointers and occupancy; a push with a pop leaves count unchanged.
  always_ff @(posedge fpga_sck or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head word is captured on the pop and held until the next pop.
  always_ff @(posedge fpga_sck or posedge reset) begin
    if (reset)      r_data <= '0;
    else if (w_pop) r_data <= r_mem[r_rptr];
  end

  // State register plus registered outputs decoded from the next state.
  always_ff @(posedge fpga_sck or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_load  <= 1'b0;
      r_tx    <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_load  <= (w_nxt == LOAD);
      r_tx    <= (w_nxt == ARMED) || (w_nxt == BUSY);
`ifdef MCU_TX_IRQ_EN
      r_irq   <= (w_nxt == ARMED);
`else
      r_irq   <= 1'b0;
`endif
    end
  end

  // Next state: pop only between frames, ignore a falling ce while armed.
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_pop)  w_nxt = LOAD;
      LOAD:    w_nxt = ARMED;
      ARMED:   if (w_rise) w_nxt = BUSY;
      BUSY:    if (w_fall) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  assign bus.full      = w_full;
  assign bus.count     = r_count;
  assign bus.load      = r_load;
  assign bus.data_load = r_data;
  assign bus.transmit  = r_tx;
  assign bus.mcu_irq   = r_irq;
endmodule

// File: tb/tb_mcu_tx_scheduler.sv
// Directed bench for mcu_tx_scheduler with a scoreboard of delivered words.
// Expected mcu_irq follows whether MCU_TX_IRQ_EN is defined for the build.
module tb_mcu_tx_scheduler;
  localparam int DEPTH = 4;
`ifdef MCU_TX_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   n_load;
  int   l0;
  logic got;
  logic [15:0] q[$];

  mcu_tx_scheduler_if #(.DEPTH(DEPTH)) bus ();

  mcu_tx_scheduler #(.DEPTH(DEPTH)) dut (
    .fpga_sck (clk),
    .reset    (rst),
    .bus      (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (bus.load === 1'b1) begin
      n_load++;
      if (q.size() == 0) check("load_unexpected", 32'd1, 32'd0);
      else check("data_load", {16'd0, bus.data_load}, {16'd0, q.pop_front()});
    end
  endtask

  task automatic wr(input logic [15:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic frame();
    bus.mcu_ce = 1'b1;
    repeat (4) step();
    bus.mcu_ce = 1'b0;
    repeat (6) step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_load = 0;
    got = 1'b0;
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.mcu_ce = 1'b0;
    repeat (3) step();
    check("rst_full", bus.full, 0);
    check("rst_count", bus.count, 0);
    check("rst_load", bus.load, 0);
    check("rst_tx", bus.transmit, 0);
    check("rst_irq", bus.mcu_irq, 0);
    check("rst_data", bus.data_load, 0);
    rst = 1'b0;
    step();

    // single word latency
    q.push_back(16'hA5C3);
    wr(16'hA5C3);
    check("lat_cnt1", bus.count, 1);
    check("lat_load0", bus.load, 0);
    check("lat_tx0", bus.transmit, 0);
    step();
    check("lat_load1", bus.load, 1);
    check("lat_tx_n1", bus.transmit, 0);
    check("lat_cnt0", bus.count, 0);
    step();
    check("lat_load_off", bus.load, 0);
    check("lat_tx", bus.transmit, 1);
    check("lat_irq", bus.mcu_irq, IRQ_ON);
    check("lat_data", bus.data_load, 16'hA5C3);
    bus.mcu_ce = 1'b1;
    repeat (4) step();
    check("busy_tx", bus.transmit, 1);
    check("busy_irq", bus.mcu_irq, 0);
    check("busy_data", bus.data_load, 16'hA5C3);
    bus.mcu_ce = 1'b0;
    repeat (6) step();
    check("idle_tx", bus.transmit, 0);
    check("n_load_1", n_load, 1);

    // three back-to-back frames
    l0 = n_load;
    q.push_back(16'h1111);
    q.push_back(16'h2222);
    q.push_back(16'h3333);
    wr(16'h1111);
    wr(16'h2222);
    wr(16'h3333);
    repeat (4) step();
    check("b2b_l1", n_load - l0, 1);
    check("b2b_cnt", bus.count, 2);
    frame();
    check("b2b_l2", n_load - l0, 2);
    frame();
    check("b2b_l3", n_load - l0, 3);
    frame();
    check("b2b_l3b", n_load - l0, 3);
    check("b2b_tx0", bus.transmit, 0);

    // overflow with ce held high
    l0 = n_load;
    bus.mcu_ce = 1'b1;
    repeat (4) step();
    for (int i = 1; i <= 5; i++) begin
      if (i < 5) q.push_back(16'hB000 + 16'(i));
      wr(16'hB000 + 16'(i));
    end
    step();
    check("ovf_full", bus.full, 1);
    check("ovf_cnt", bus.count, 4);
    check("ovf_noload", n_load - l0, 0);
    bus.mcu_ce = 1'b0;
    repeat (6) step();
    repeat (4) frame();
    check("ovf_l4", n_load - l0, 4);
    check("ovf_cnt0", bus.count, 0);

    // push coincident with pop while full
    l0 = n_load;
    bus.mcu_ce = 1'b1;
    repeat (4) step();
    for (int i = 1; i <= 4; i++) begin
      q.push_back(16'hC000 + 16'(i));
      wr(16'hC000 + 16'(i));
    end
    check("pp_full", bus.full, 1);
    q.push_back(16'hC005);
    bus.mcu_ce = 1'b0;
    bus.wr_en = 1'b1;
    bus.wr_data = 16'hC005;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (bus.load === 1'b1) got = 1'b1;
    end
    bus.wr_en = 1'b0;
    check("pp_seen", got, 1);
    check("pp_cnt4", bus.count, 4);
    step();
    check("pp_full2", bus.full, 1);
    repeat (5) frame();
    check("pp_l5", n_load - l0, 5);
    check("pp_cnt0", bus.count, 0);

    // reset in BUSY with two queued
    l0 = n_load;
    q.push_back(16'hD001);
    wr(16'hD001);
    wr(16'hD002);
    wr(16'hD003);
    repeat (4) step();
    check("rb_cnt2", bus.count, 2);
    bus.mcu_ce = 1'b1;
    repeat (4) step();
    check("rb_busy_tx", bus.transmit, 1);
    #1 rst = 1'b1;
    #1;
    check("rb_tx", bus.transmit, 0);
    check("rb_irq", bus.mcu_irq, 0);
    check("rb_load", bus.load, 0);
    check("rb_cnt", bus.count, 0);
    check("rb_full", bus.full, 0);
    check("rb_data", bus.data_load, 0);
    step();
    rst = 1'b0;
    repeat (4) step();
    bus.mcu_ce = 1'b0;
    repeat (6) step();
    frame();
    frame();
    check("rb_noload", n_load - l0, 1);
    check("rb_tx_end", bus.transmit, 0);
    check("q_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
